mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Sequencer for the fixed-point MAC datapath (`mac_wrapper`, Q6.9 16-bit operands). It accepts a dot-product job of 1..MAX_LEN operand pairs and clears the MAC. It streams the pairs in under valid/ready, waits out the MAC pipeline, then returns the accumulated result under valid/ready. It sits between the operand source (buffer/DMA) and the MAC, replacing bench-driven sequencing.

## Interface
- DATA_W, 16, operand/result width (Q6.9)
- MAX_LEN, 16, max pairs per job
- MAC_LAT, 3, cycles from final `mac_en` cycle to valid `mac_result`
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- len  in  5  pairs in job; legal 1..MAX_LEN
- err  out  1  1-cycle pulse: start with illegal len
- busy  out  1  high in any state but IDLE
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  DATA_W  operand pair
- mac_clr  out  1  1-cycle accumulator clear
- mac_en  out  1  operands on mac_a/mac_b are valid this cycle
- mac_a, mac_b  out  DATA_W  registered operands
- mac_count  out  5  pairs issued to MAC this job
- mac_result  in  DATA_W  MAC accumulator output
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  DATA_W  captured result

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: start && 1<=len<=MAX_LEN -> latch len, go CLEAR. start with len 0 or >MAX_LEN -> err pulse next cycle, stay IDLE.
- CLEAR: mac_clr=1 for one cycle, mac_count<=0 -> STREAM.
- STREAM: in_ready=1 while accepted<len. Each in_valid&&in_ready registers in_a/in_b to mac_a/mac_b and drives mac_en=1 the next cycle; mac_count increments with mac_en. Source bubbles (in_valid=0) give mac_en=0 and hold mac_a/mac_b. Last accept -> DRAIN.
- DRAIN: the first cycle carries the final mac_en. A down-counter then runs MAC_LAT further cycles. At the end of the last DRAIN cycle, res_data<=mac_result -> DONE.
- DONE: res_valid=1, res_data stable until res_ready. On res_valid&&res_ready -> IDLE, the same cycle start is not accepted.
- start outside IDLE is ignored: no err, no effect.
- Operands and result pass through unmodified. No arithmetic in this block; the width/saturation rules belong to the MAC.
- Reset (async assert at any time, including mid-job): state IDLE, all outputs 0 (in_ready, mac_clr, mac_en, mac_a, mac_b, mac_count, res_valid, res_data, busy, err). Released job is lost; no partial result.

## Timing
- start in cycle 0 -> CLEAR cycle 1 -> in_ready from cycle 2.
- With back-to-back in_valid and len=N: accepts cycles 2..N+1, mac_en cycles 3..N+2, capture end of cycle N+2+MAC_LAT, res_valid from cycle N+3+MAC_LAT.
- Example: N=8, MAC_LAT=3 -> res_valid cycle 14.
- Each source bubble adds one cycle. The result stall (res_ready=0) holds DONE indefinitely.
- in_ready is a registered state decode. It must not depend combinationally on in_valid.
- Minimum job-to-job spacing: one IDLE cycle after result handshake.

## Structure
- Package mac_pkg: DATA_W, FRAC_W (9), MAX_LEN, MAC_LAT defaults, and the state enum typedef. Shared with mac_wrapper and the bench.
- Single module. The drain and issue counters are inline; no sub-module warranted.
- Top-level integration: mac_count drives the wrapper `counter` port, mac_clr/mac_en drive its clear/enable.

## Test plan
- len=4, A=0x0400 (2.0), B=0x0300 (1.5) every pair, continuous valid, behavioural MAC with MAC_LAT=3 -> mac_clr cycle 1, mac_en cycles 3..6, res_data=0x1800 (12.0), res_valid cycle 10.
- len=8, A∈[0x0000,0x0A00], B∈[0xF600,0xFE00] random -> res_data equals the bench real sum scaled by 2^9 within 1 LSB per product; mac_count ends at 8.
- len=3, in_valid low on alternate cycles -> mac_en only on accepted pairs, res_valid delayed by 2 cycles vs. continuous case.
- start with len=0, then len=17 -> err pulse each, busy stays 0, no mac_clr.
- res_ready held 0 for 5 cycles in DONE; start pulsed meanwhile -> res_data stable, start ignored, IDLE only after handshake.
- reset asserted in STREAM after 2 of 8 pairs -> all outputs 0 immediately. After release, a new len=2 job completes correctly with mac_count=2.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the fixed-point MAC slice.
// Used by mac_seq_ctrl, mac_wrapper and the bench.
package mac_pkg;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 9;
    localparam int MAX_LEN = 16;
    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } mac_state_e;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: clears the MAC, streams operand pairs,
// waits out the MAC pipeline and hands back the accumulated result.
module mac_seq_ctrl #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int MAX_LEN = mac_pkg::MAX_LEN,
    parameter int MAC_LAT = mac_pkg::MAC_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        len,
    output logic              err,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic [4:0]        mac_count,
    input  logic [DATA_W-1:0] mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
);
    import mac_pkg::*;

    localparam int DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    mac_state_e        state_q, state_d;
    logic [4:0]        len_q, len_d;
    logic [4:0]        acc_q, acc_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [DATA_W-1:0] mac_a_q, mac_a_d;
    logic [DATA_W-1:0] mac_b_q, mac_b_d;
    logic              mac_en_q, mac_en_d;
    logic [4:0]        mac_count_q, mac_count_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              err_q, err_d;
    logic              fire;
    logic              len_ok;

    // in_ready decodes registered state only, never in_valid
    assign in_ready  = (state_q == ST_STREAM);
    assign mac_clr   = (state_q == ST_CLEAR);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign mac_en    = mac_en_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_count = mac_count_q;
    assign res_data  = res_data_q;

    assign fire   = in_valid && in_ready;
    assign len_ok = (len != 5'd0) && (int'(len) <= MAX_LEN);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        drain_d     = drain_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_en_d    = 1'b0;
        mac_count_d = mac_count_q;
        res_data_d  = res_data_q;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = len;
                        state_d = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mac_count_d = '0;
                acc_d       = '0;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (fire) begin
                    mac_a_d     = in_a;
                    mac_b_d     = in_b;
                    mac_en_d    = 1'b1;
                    mac_count_d = mac_count_q + 5'd1;
                    acc_d       = acc_q + 5'd1;
                    if (acc_q + 5'd1 == len_q) begin
                        drain_d = DRN_W'(MAC_LAT);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // first DRAIN cycle still carries the final mac_en
                if (drain_q == '0) begin
                    res_data_d = mac_result;
                    state_d    = ST_DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            acc_q       <= '0;
            drain_q     <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_count_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            drain_q     <= drain_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_en_q    <= mac_en_d;
            mac_count_q <= mac_count_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

endmodule
